alu_seq: RTL and testbench

- Parametrised, handshaked successor of the 4-bit datapath ALU: signed two's-complement datapath of WIDTH bits with the same 4-bit opcode space.
- Adds an iterative signed multiplier, arithmetic shift right, a selectable saturate/wrap mode, and zero/negative flags.
- Sits between the register-file read stage and the write-back stage; valid/ready on both sides replaces the fixed present-state gating.

---
 rtl/alu_seq_if.sv | 40 ++++
 rtl/alu_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Request/response bundle for the sequential ALU. The request
//               side (in_valid/in_ready, op, a, b) carries one operation from
//               the register-file read stage; the response side
//               (out_valid/out_ready, result, flags) delivers it to
//               write-back. busy reports that the ALU is not idle.
//               master : producer/consumer side (drives requests, out_ready)
//               slave  : ALU side (drives in_ready, results, flags, busy)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             unf;
    logic             zero;
    logic             neg;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, ovf, unf, zero, neg, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, ovf, unf, zero, neg, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked signed ALU, WIDTH-bit two's complement. Logic,
//               add/sub, shifts complete in one cycle; signed multiply runs
//               WIDTH shift-add cycles. Optional saturation on overflow.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - alu_seq_if.slave (request, response, flags, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam logic [1:0]       c_IDLE   = 2'd0;
    localparam logic [1:0]       c_MUL    = 2'd1;
    localparam logic [1:0]       c_DONE   = 2'd2;
    localparam logic [3:0]       c_OP_MUL = 4'd12;
    localparam int               c_CW     = $clog2(WIDTH);
    localparam logic [c_CW-1:0]  c_LAST   = c_CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_WIDTH_V = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] c_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_result;
    logic               r_ovf, r_unf, r_zero, r_neg;
    logic [c_CW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;

    logic [WIDTH:0]     w_sum, w_dif;
    logic               w_big;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_ovf, w_alu_unf;
    logic [2*WIDTH-1:0] w_pp, w_acc_nxt;
    logic               w_mul_fit, w_mul_ovf, w_mul_unf;
    logic [WIDTH-1:0]   w_ld_res;
    logic               w_ld_ovf, w_ld_unf;

    // Flags are always reported; the value clamps only when saturation is on.
    function automatic logic [WIDTH-1:0] f_sat(input logic [WIDTH-1:0] v,
                                               input logic o, input logic u);
        if (SAT_EN && o)      return c_MAX;
        else if (SAT_EN && u) return c_MIN;
        else                  return v;
    endfunction

    // Single-cycle datapath; add/sub use one guard bit to classify overflow.
    always_comb begin
        w_sum     = {bus.a[WIDTH-1], bus.a} + {bus.b[WIDTH-1], bus.b};
        w_dif     = {bus.a[WIDTH-1], bus.a} - {bus.b[WIDTH-1], bus.b};
        w_big     = (bus.b >= c_WIDTH_V);
        w_alu_res = r_result;
        w_alu_ovf = 1'b0;
        w_alu_unf = 1'b0;
        case (bus.op)
            4'd1:  w_alu_res = bus.b;
            4'd2,
            4'd3:  w_alu_res = bus.a;
            4'd4:  w_alu_res = ~bus.a;
            4'd5:  w_alu_res = bus.a & bus.b;
            4'd6:  w_alu_res = bus.a | bus.b;
            4'd7:  w_alu_res = bus.a ^ bus.b;
            4'd8:  w_alu_res = ~(bus.a & bus.b);
            4'd9:  w_alu_res = ~(bus.a | bus.b);
            4'd10: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_ovf = (w_sum[WIDTH:WIDTH-1] == 2'b01);
                w_alu_unf = (w_sum[WIDTH:WIDTH-1] == 2'b10);
            end
            4'd11: begin
                w_alu_res = w_dif[WIDTH-1:0];
                w_alu_ovf = (w_dif[WIDTH:WIDTH-1] == 2'b01);
                w_alu_unf = (w_dif[WIDTH:WIDTH-1] == 2'b10);
            end
            4'd13: w_alu_res = w_big ? {WIDTH{bus.a[WIDTH-1]}} : WIDTH'($signed(bus.a) >>> bus.b);
            4'd14: w_alu_res = w_big ? '0 : bus.a << bus.b;
            4'd15: w_alu_res = w_big ? '0 : bus.a >> bus.b;
            default: w_alu_res = r_result;  // NOP (and MUL, which uses its own path)
        endcase
    end

    // Multiplier bit WIDTH-1 carries weight -2^(WIDTH-1), so the final
    // partial product is subtracted rather than added.
    always_comb begin
        w_pp      = r_mplier[0] ? r_mcand : '0;
        w_acc_nxt = (r_cnt == c_LAST) ? (r_acc - w_pp) : (r_acc + w_pp);
        w_mul_fit = (&w_acc_nxt[2*WIDTH-1:WIDTH-1]) | ~(|w_acc_nxt[2*WIDTH-1:WIDTH-1]);
        w_mul_ovf = ~w_mul_fit & ~w_acc_nxt[2*WIDTH-1];
        w_mul_unf = ~w_mul_fit &  w_acc_nxt[2*WIDTH-1];
    end

    always_comb begin
        if (r_state == c_MUL) begin
            w_ld_res = f_sat(w_acc_nxt[WIDTH-1:0], w_mul_ovf, w_mul_unf);
            w_ld_ovf = w_mul_ovf;
            w_ld_unf = w_mul_unf;
        end else begin
            w_ld_res = f_sat(w_alu_res, w_alu_ovf, w_alu_unf);
            w_ld_ovf = w_alu_ovf;
            w_ld_unf = w_alu_unf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.op == c_OP_MUL) begin
                            r_mcand  <= {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
                            r_mplier <= bus.b;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_state  <= c_MUL;
                        end else begin
                            r_result <= w_ld_res;
                            r_ovf    <= w_ld_ovf;
                            r_unf    <= w_ld_unf;
                            r_zero   <= (w_ld_res == '0);
                            r_neg    <= w_ld_res[WIDTH-1];
                            r_state  <= c_DONE;
                        end
                    end
                end
                c_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_result <= w_ld_res;
                        r_ovf    <= w_ld_ovf;
                        r_unf    <= w_ld_unf;
                        r_zero   <= (w_ld_res == '0);
                        r_neg    <= w_ld_res[WIDTH-1];
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_IDLE);
    assign bus.out_valid = (r_state == c_DONE);
    assign bus.busy      = (r_state != c_IDLE);
    assign bus.result    = r_result;
    assign bus.ovf       = r_ovf;
    assign bus.unf       = r_unf;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq, WIDTH = 8. Two
//               instances share stimulus: dut0 saturates, dut1 wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8)) bus0 ();
    alu_seq_if #(.WIDTH(8)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.out_ready = out_ready;
    assign bus0.op        = op;
    assign bus0.a         = a;
    assign bus0.b         = b;
    assign bus1.in_valid  = in_valid;
    assign bus1.out_ready = out_ready;
    assign bus1.op        = op;
    assign bus1.a         = a;
    assign bus1.b         = b;

    alu_seq #(.WIDTH(8), .SAT_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    alu_seq #(.WIDTH(8), .SAT_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // Issue one op from idle (called at a negedge); returns at the negedge
    // where out_valid is first seen. lat = cycles after accept, -1 on timeout.
    task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          output int lat, output int busy_cyc);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        busy_cyc = 0;
        while (!bus0.out_valid && lat < 40) begin
            if (bus0.busy && !bus0.in_ready) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        if (!bus0.out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus0.result !== 8'h00) $display("FAIL reset_result got %h want 00", bus0.result); else n_pass++;
        n_checks++; if ({bus0.ovf, bus0.unf, bus0.zero, bus0.neg} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {bus0.ovf, bus0.unf, bus0.zero, bus0.neg}); else n_pass++;
        n_checks++; if ({bus0.out_valid, bus0.busy, bus0.in_ready} !== 3'b001)
            $display("FAIL reset_hs got %b want 001", {bus0.out_valid, bus0.busy, bus0.in_ready}); else n_pass++;
    endtask

    task automatic test_add();
        int lat, bc;
        run_op(4'd10, 8'd100, 8'd50, lat, bc);
        n_checks++; if (lat !== 1) $display("FAIL add_latency got %0d want 1", lat); else n_pass++;
        n_checks++; if (bus0.result !== 8'h7F) $display("FAIL add_sat_result got %h want 7f", bus0.result); else n_pass++;
        n_checks++; if ({bus0.ovf, bus0.unf} !== 2'b10) $display("FAIL add_sat_flags got %b want 10", {bus0.ovf, bus0.unf}); else n_pass++;
        n_checks++; if (bus1.result !== 8'h96) $display("FAIL add_wrap_result got %h want 96", bus1.result); else n_pass++;
        n_checks++; if ({bus1.ovf, bus1.neg} !== 2'b11) $display("FAIL add_wrap_flags got %b want 11", {bus1.ovf, bus1.neg}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({bus0.in_ready, bus0.out_valid} !== 2'b10)
            $display("FAIL add_ready_after got %b want 10", {bus0.in_ready, bus0.out_valid}); else n_pass++;
    endtask

    task automatic test_sub();
        int lat, bc;
        run_op(4'd11, 8'h9C, 8'd50, lat, bc);
        n_checks++; if (bus0.result !== 8'h80) $display("FAIL sub_unf_result got %h want 80", bus0.result); else n_pass++;
        n_checks++; if ({bus0.ovf, bus0.unf, bus0.zero, bus0.neg} !== 4'b0101)
            $display("FAIL sub_unf_flags got %b want 0101", {bus0.ovf, bus0.unf, bus0.zero, bus0.neg}); else n_pass++;
        n_checks++; if ({bus1.result, bus1.unf} !== {8'h6A, 1'b1})
            $display("FAIL sub_wrap got %h/%b want 6a/1", bus1.result, bus1.unf); else n_pass++;
        @(negedge clk);
        run_op(4'd11, 8'd5, 8'd5, lat, bc);
        n_checks++; if ({bus0.result, bus0.ovf, bus0.unf, bus0.zero, bus0.neg} !== {8'h00, 4'b0010})
            $display("FAIL sub_zero got %h/%b want 00/0010", bus0.result, {bus0.ovf, bus0.unf, bus0.zero, bus0.neg}); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int lat, bc;
        run_op(4'd12, 8'hF9, 8'd9, lat, bc);
        n_checks++; if (lat !== 9) $display("FAIL mul_latency got %0d want 9", lat); else n_pass++;
        n_checks++; if (bc !== 8) $display("FAIL mul_busy_cycles got %0d want 8", bc); else n_pass++;
        n_checks++; if ({bus0.result, bus0.ovf, bus0.unf} !== {8'hC1, 2'b00})
            $display("FAIL mul_neg got %h/%b want c1/00", bus0.result, {bus0.ovf, bus0.unf}); else n_pass++;
        @(negedge clk);
        run_op(4'd12, 8'd16, 8'd16, lat, bc);
        n_checks++; if ({bus0.result, bus0.ovf, bus0.unf} !== {8'h7F, 2'b10})
            $display("FAIL mul_ovf got %h/%b want 7f/10", bus0.result, {bus0.ovf, bus0.unf}); else n_pass++;
        n_checks++; if ({bus1.result, bus1.ovf, bus1.zero} !== {8'h00, 2'b11})
            $display("FAIL mul_ovf_wrap got %h/%b want 00/11", bus1.result, {bus1.ovf, bus1.zero}); else n_pass++;
        @(negedge clk);
        run_op(4'd12, 8'hF0, 8'd16, lat, bc);
        n_checks++; if ({bus0.result, bus0.ovf, bus0.unf} !== {8'h80, 2'b01})
            $display("FAIL mul_unf got %h/%b want 80/01", bus0.result, {bus0.ovf, bus0.unf}); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_shift();
        int lat, bc;
        run_op(4'd13, 8'h90, 8'd2, lat, bc);
        n_checks++; if (bus0.result !== 8'hE4) $display("FAIL sra got %h want e4", bus0.result); else n_pass++;
        @(negedge clk);
        run_op(4'd15, 8'h90, 8'd2, lat, bc);
        n_checks++; if (bus0.result !== 8'h24) $display("FAIL srl got %h want 24", bus0.result); else n_pass++;
        @(negedge clk);
        run_op(4'd14, 8'h01, 8'd9, lat, bc);
        n_checks++; if ({bus0.result, bus0.zero, bus0.ovf} !== {8'h00, 2'b10})
            $display("FAIL sll_big got %h/%b want 00/10", bus0.result, {bus0.zero, bus0.ovf}); else n_pass++;
        @(negedge clk);
        run_op(4'd13, 8'h80, 8'd12, lat, bc);
        n_checks++; if ({bus0.result, bus0.neg} !== {8'hFF, 1'b1})
            $display("FAIL sra_big got %h/%b want ff/1", bus0.result, bus0.neg); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        op = 4'd7; a = 8'h5A; b = 8'h0F; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op = 4'd10; a = 8'd1; b = 8'd2;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({bus0.out_valid, bus0.in_ready, bus0.result} !== {2'b10, 8'h55})
                $display("FAIL bp_hold cyc %0d got %b/%h want 10/55", i, {bus0.out_valid, bus0.in_ready}, bus0.result); else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus0.in_ready, bus0.out_valid} !== 2'b10)
            $display("FAIL bp_release got %b want 10", {bus0.in_ready, bus0.out_valid}); else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if ({bus0.out_valid, bus0.result} !== {1'b1, 8'h03})
            $display("FAIL bp_second got %b/%h want 1/03", bus0.out_valid, bus0.result); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        int lat, bc;
        logic seen;
        op = 4'd12; a = 8'd3; b = 8'd5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({bus0.result, bus0.ovf, bus0.unf, bus0.zero, bus0.neg} !== 12'h000)
            $display("FAIL rst_mid_outputs got %h/%b want 00/0000", bus0.result, {bus0.ovf, bus0.unf, bus0.zero, bus0.neg}); else n_pass++;
        n_checks++; if ({bus0.out_valid, bus0.busy, bus0.in_ready} !== 3'b001)
            $display("FAIL rst_mid_hs got %b want 001", {bus0.out_valid, bus0.busy, bus0.in_ready}); else n_pass++;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | bus0.out_valid;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rst_mid_no_valid got %b want 0", seen); else n_pass++;
        run_op(4'd0, 8'h00, 8'h00, lat, bc);
        n_checks++; if ({bus0.result, bus0.zero, bus0.ovf, bus0.unf} !== {8'h00, 3'b100})
            $display("FAIL nop_after_rst got %h/%b want 00/100", bus0.result, {bus0.zero, bus0.ovf, bus0.unf}); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_shift();
        test_back_to_back();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
